cmd_frame_assembler: RTL
========================

# cmd_frame_assembler

- Collects the synchronized UART RX byte stream, one `rx_valid` pulse per byte, into complete command frames.
- Presents each frame to the system controller as one parallel word with a valid/ready handshake.
- Sits in the REF_CLK domain, directly downstream of the RX data synchronizer and upstream of the controller.
- Checks opcodes, drops partial frames after a byte-gap timeout, and flags bytes lost while a frame is pending.

## Interface
Single clock; reset is synchronous, active-low.

Parameters:
- `DATA_WIDTH`, 8: byte width.
- `RF_ADDR`, 4: register-file address width.
- `TIMEOUT_CYC`, 1024: maximum idle clk cycles between bytes of one frame; legal range ≥ 2.

Ports:
- `clk`, in, 1: REF_CLK domain clock.
- `rst`, in, 1: synchronous active-low reset.
- `rx_data`, in, DATA_WIDTH: synchronized RX byte; valid only when `rx_valid`=1.
- `rx_valid`, in, 1: one-cycle pulse per received byte.
- `frm_valid`, out, 1: complete frame available.
- `frm_ready`, in, 1: consumer accepts the frame.
- `frm_cmd`, out, 2: frame kind. 0=WR, 1=RD, 2=ALU_OP, 3=ALU_NOP.
- `frm_addr`, out, RF_ADDR: register address.
- `frm_wdata`, out, DATA_WIDTH: write data.
- `frm_op_a`, out, DATA_WIDTH: ALU operand A.
- `frm_op_b`, out, DATA_WIDTH: ALU operand B.
- `frm_alu_fun`, out, 4: ALU function.
- `err_opcode`, out, 1: one-cycle pulse, unknown opcode.
- `err_timeout`, out, 1: one-cycle pulse, partial frame aborted.
- `err_overrun`, out, 1: one-cycle pulse, byte dropped while `frm_valid`=1.

## Operation
Opcodes and total frame lengths:
- 0xAA, WR: opcode, addr, data (3 bytes).
- 0xBB, RD: opcode, addr (2 bytes).
- 0xCC, ALU_OP: opcode, A, B, fun (4 bytes).
- 0xDD, ALU_NOP: opcode, fun (2 bytes).

Field extraction:
- Address byte: `frm_addr` = byte[RF_ADDR-1:0]; upper bits are ignored.
- Function byte: `frm_alu_fun` = byte[3:0]; upper bits are ignored.
- Fields not used by a frame kind are driven to 0.

State machine:
- IDLE:
  - Byte with a known opcode: latch `frm_cmd`, clear all other fields, set byte index to 1, go to COLLECT.
  - Byte with an unknown opcode: pulse `err_opcode`, stay in IDLE.
- COLLECT:
  - Each byte is stored into the field selected by `frm_cmd` and the byte index; the index increments.
  - On the final byte, go to HOLD.
  - The gap counter clears on every byte and otherwise increments.
  - When the counter reaches TIMEOUT_CYC-1 with no byte that cycle: pulse `err_timeout`, clear fields, go to IDLE.
- HOLD:
  - `frm_valid`=1; all `frm_*` fields stay stable.
  - `frm_valid`=1 and `frm_ready`=1: handshake completes, go to IDLE.
  - A byte arriving without a handshake is dropped and `err_overrun` pulses.

Boundary conditions:
- Handshake and byte in the same cycle: the frame completes and the byte is processed as an IDLE opcode byte, so back-to-back frames lose no byte.
- Byte and timeout expiry in the same cycle: the byte wins, is stored, and the counter clears.
- `frm_ready` outside HOLD has no effect.
- Reset mid-frame: partial contents are discarded.

## Timing
- Reset values: state IDLE, all outputs 0, gap counter 0, byte index 0.
- All outputs are registered; no combinational path from inputs to outputs.
- Frame latency: `frm_valid` rises the cycle after the `rx_valid` of the last byte.
- `frm_valid` falls the cycle after the accepting `frm_ready`.
- Error pulses are high exactly one cycle, in the cycle after the causing event.
- Timeout: `err_timeout` asserts TIMEOUT_CYC cycles after the last accepted byte.
- Throughput: one byte per clk accepted in IDLE and COLLECT; the RX rate is far below this in practice.

## Structure
- Package `cmd_frame_pkg` holds:
  - Opcode constants `OP_WR`, `OP_RD`, `OP_ALU`, `OP_ALU_NOP`.
  - The 2-bit `frm_cmd` encoding.
  - The state encoding (IDLE, COLLECT, HOLD).
  - A frame-length function mapping `frm_cmd` to byte count.
- One natural sub-module, `frame_gap_timer`: a loadable gap counter with `clear`, `enable` and a `expired` output, width $clog2(TIMEOUT_CYC).
- Everything else lives in the top module.

## Test plan
- **WR frame:** bytes 0xAA, 0x05, 0x3C, `frm_ready`=1.
  - Expect `frm_valid` for one cycle with `frm_cmd`=0, `frm_addr`=5, `frm_wdata`=0x3C.
  - All other fields 0.
- **ALU_OP with backpressure:** bytes 0xCC, 0x12, 0x34, 0x07, `frm_ready` held 0 for 10 cycles.
  - Fields stay `frm_op_a`=0x12, `frm_op_b`=0x34, `frm_alu_fun`=7 throughout.
  - A byte 0x55 sent during the hold gives one `err_overrun` pulse and leaves the frame unchanged.
- **Unknown opcode and recovery:** byte 0x41 gives an `err_opcode` pulse and no `frm_valid`.
  - Following bytes 0xBB, 0x0F give an RD frame with `frm_addr`=0xF.
- **Timeout with TIMEOUT_CYC=16:** byte 0xAA, then silence.
  - `err_timeout` at cycle 16 after the byte.
  - Following bytes 0xDD, 0x02 give an ALU_NOP frame with `frm_alu_fun`=2.
- **Back-to-back frames:** 0xBB 0x03 completes.
  - Next opcode 0xDD arrives in the same cycle as `frm_ready`.
  - Second frame (0xDD, 0x01) is delivered correctly.
- **Reset mid-frame:** assert `rst`=0 after 0xCC, 0x12.
  - All outputs return to 0.
  - Subsequent 0xBB, 0x01 yields a clean RD frame.

Source files
------------

// File: rtl/cmd_frame_pkg.sv
// Shared constants for the command frame assembler: opcodes, frame kinds,
// FSM state encoding and the per-kind frame length.
package cmd_frame_pkg;

  localparam logic [7:0] OP_WR      = 8'hAA;
  localparam logic [7:0] OP_RD      = 8'hBB;
  localparam logic [7:0] OP_ALU     = 8'hCC;
  localparam logic [7:0] OP_ALU_NOP = 8'hDD;

  localparam logic [1:0] CMD_WR      = 2'd0;
  localparam logic [1:0] CMD_RD      = 2'd1;
  localparam logic [1:0] CMD_ALU     = 2'd2;
  localparam logic [1:0] CMD_ALU_NOP = 2'd3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  // Total bytes in a frame, opcode included.
  function automatic logic [2:0] frame_len(input logic [1:0] cmd);
    case (cmd)
      CMD_WR:  return 3'd3;
      CMD_RD:  return 3'd2;
      CMD_ALU: return 3'd4;
      default: return 3'd2;
    endcase
  endfunction

  function automatic logic opcode_known(input logic [7:0] op);
    return (op == OP_WR) || (op == OP_RD) || (op == OP_ALU) || (op == OP_ALU_NOP);
  endfunction

  function automatic logic [1:0] opcode_cmd(input logic [7:0] op);
    case (op)
      OP_RD:      return CMD_RD;
      OP_ALU:     return CMD_ALU;
      OP_ALU_NOP: return CMD_ALU_NOP;
      default:    return CMD_WR;
    endcase
  endfunction

endpackage

// File: rtl/cmd_frame_assembler_gap_timer.sv
// Inter-byte gap counter: cleared on every byte, counts idle cycles and
// saturates at TIMEOUT_CYC-1, where it reports expiry.
module frame_gap_timer #(
  parameter int TIMEOUT_CYC = 1024,
  localparam int CNT_W = $clog2(TIMEOUT_CYC)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] count;

  assign expired = (count == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cmd_frame_assembler.sv
// Assembles the synchronized UART RX byte stream into command frames and
// hands each one to the controller over a valid/ready handshake.
module cmd_frame_assembler
  import cmd_frame_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int RF_ADDR     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  frm_valid,
  input  logic                  frm_ready,
  output logic [1:0]            frm_cmd,
  output logic [RF_ADDR-1:0]    frm_addr,
  output logic [DATA_WIDTH-1:0] frm_wdata,
  output logic [DATA_WIDTH-1:0] frm_op_a,
  output logic [DATA_WIDTH-1:0] frm_op_b,
  output logic [3:0]            frm_alu_fun,
  output logic                  err_opcode,
  output logic                  err_timeout,
  output logic                  err_overrun
);

  logic [1:0] state;
  logic [1:0] byte_idx;
  logic       gap_expired;
  logic       last_byte;
  logic       take_opcode;
  logic [7:0] op_byte;

  assign op_byte   = rx_data[7:0];
  assign last_byte = ({1'b0, byte_idx} == frame_len(frm_cmd) - 3'd1);
  // A handshake frees the assembler in the same cycle, so a byte arriving
  // alongside frm_ready is treated as the next opcode rather than dropped.
  assign take_opcode = rx_valid &&
                       ((state == ST_IDLE) || ((state == ST_HOLD) && frm_ready));

  frame_gap_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_gap_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   ((state != ST_COLLECT) || rx_valid),
    .enable  ((state == ST_COLLECT) && !rx_valid),
    .expired (gap_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      byte_idx    <= 2'd0;
      frm_valid   <= 1'b0;
      frm_cmd     <= 2'd0;
      frm_addr    <= '0;
      frm_wdata   <= '0;
      frm_op_a    <= '0;
      frm_op_b    <= '0;
      frm_alu_fun <= 4'd0;
      err_opcode  <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_opcode  <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;

      case (state)
        ST_COLLECT: begin
          if (rx_valid) begin
            case (frm_cmd)
              CMD_WR: begin
                if (byte_idx == 2'd1) frm_addr  <= rx_data[RF_ADDR-1:0];
                else                  frm_wdata <= rx_data;
              end
              CMD_RD: frm_addr <= rx_data[RF_ADDR-1:0];
              CMD_ALU: begin
                case (byte_idx)
                  2'd1:    frm_op_a    <= rx_data;
                  2'd2:    frm_op_b    <= rx_data;
                  default: frm_alu_fun <= rx_data[3:0];
                endcase
              end
              default: frm_alu_fun <= rx_data[3:0];
            endcase
            if (last_byte) begin
              state     <= ST_HOLD;
              frm_valid <= 1'b1;
              byte_idx  <= 2'd0;
            end else begin
              byte_idx <= byte_idx + 2'd1;
            end
          end else if (gap_expired) begin
            err_timeout <= 1'b1;
            state       <= ST_IDLE;
            byte_idx    <= 2'd0;
            frm_cmd     <= 2'd0;
            frm_addr    <= '0;
            frm_wdata   <= '0;
            frm_op_a    <= '0;
            frm_op_b    <= '0;
            frm_alu_fun <= 4'd0;
          end
        end
        ST_HOLD: begin
          if (frm_ready) begin
            frm_valid <= 1'b0;
            state     <= ST_IDLE;
            byte_idx  <= 2'd0;
          end else if (rx_valid) begin
            err_overrun <= 1'b1;
          end
        end
        ST_IDLE: ;
        default: state <= ST_IDLE;
      endcase

      if (take_opcode) begin
        if (opcode_known(op_byte)) begin
          frm_cmd     <= opcode_cmd(op_byte);
          frm_addr    <= '0;
          frm_wdata   <= '0;
          frm_op_a    <= '0;
          frm_op_b    <= '0;
          frm_alu_fun <= 4'd0;
          byte_idx    <= 2'd1;
          state       <= ST_COLLECT;
        end else begin
          err_opcode <= 1'b1;
        end
      end
    end
  end

endmodule
